// File: rtl/fp16_issue_pkg.sv
// Shared types and widths for the fp16 multiply issue/collect stage.
// Optional statistics are enabled with FP16_ISSUE_STATS_EN.
package fp16_issue_pkg;

   typedef enum logic [1:0] {
      DRAIN = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } issue_state_e;

   localparam int FP16_W = 16;
   localparam int STAT_W = 32;

endpackage

// File: rtl/fp16_res_fifo.sv
// First-word-fall-through result FIFO with synchronous clear.
// Push and pop may coincide at any occupancy, including full.
module fp16_res_fifo
   import fp16_issue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = FP16_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_dout,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic [W-1:0] r_mem [DEPTH];
   logic         w_wr;
   logic         w_rd;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_wr    = i_push && (!o_full || i_pop);
   assign w_rd    = i_pop && !o_empty;
   assign o_dout  = r_mem[r_rptr[AW-1:0]];

   // Pointer update; clear wins over any push/pop in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_clr) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage is reset so the head reads zero while empty after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr && !i_clr) begin
         r_mem[r_wptr[AW-1:0]] <= i_din;
      end
   end

endmodule

// File: rtl/fp16_mul_issue.sv
// Credit-based operand issue and result collection around the fp16 multiply core.
// Define FP16_ISSUE_STATS_EN to add the stat_issued/stat_returned counters.
module fp16_mul_issue
   import fp16_issue_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int MUL_LATENCY = 6
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [FP16_W-1:0] s_op_a_tdata,
   input  logic [FP16_W-1:0] s_op_b_tdata,
   input  logic              s_op_tvalid,
   output logic              s_op_tready,
   output logic [FP16_W-1:0] mul_a_tdata,
   output logic [FP16_W-1:0] mul_b_tdata,
   output logic              mul_a_tvalid,
   output logic              mul_b_tvalid,
   input  logic              mul_result_tvalid,
   input  logic [FP16_W-1:0] mul_result_tdata,
   output logic [FP16_W-1:0] m_res_tdata,
   output logic              m_res_tvalid,
   input  logic              m_res_tready,
   input  logic              flush,
   output logic              busy,
   output logic              err
`ifdef FP16_ISSUE_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_issued,
   output logic [STAT_W-1:0] stat_returned
`endif
);

   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W = $clog2(MUL_LATENCY + 2);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   issue_state_e      r_state;
   issue_state_e      w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CW-1:0]     r_reserved;
   logic [CW-1:0]     r_inflight;
   logic [FP16_W-1:0] r_mul_a;
   logic [FP16_W-1:0] r_mul_b;
   logic              r_mul_v;
   logic              r_err;

   logic              w_op_hs;
   logic              w_res_hs;
   logic              w_res_in;
   logic              w_orphan;
   logic              w_ret;
   logic              w_flush_go;
   logic              w_push;
   logic              w_ovf;
   logic              w_full;
   logic              w_empty;
   logic [FP16_W-1:0] w_head;

   assign s_op_tready  = (r_state == RUN) && (r_reserved < DEPTH_C);
   assign w_op_hs      = s_op_tvalid && s_op_tready;
   assign m_res_tvalid = (r_state != FLUSH) && !w_empty;
   assign m_res_tdata  = w_head;
   assign w_res_hs     = m_res_tvalid && m_res_tready;

   // Core output is untrusted while draining after reset
   assign w_res_in   = mul_result_tvalid && (r_state != DRAIN);
   assign w_orphan   = w_res_in && (r_inflight == '0);
   assign w_ret      = w_res_in && !w_orphan;
   assign w_flush_go = (r_state == RUN) && flush;
   assign w_push     = w_ret && (r_state == RUN) && !flush;
   assign w_ovf      = w_push && w_full && !w_res_hs;

   assign mul_a_tdata  = r_mul_a;
   assign mul_b_tdata  = r_mul_b;
   assign mul_a_tvalid = r_mul_v;
   assign mul_b_tvalid = r_mul_v;
   assign err          = r_err;
   assign busy         = !((r_state == RUN) && (r_reserved == '0));

   fp16_res_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (FP16_W)
   ) u_fifo (
      .clk     (aclk),
      .rst_n   (aresetn),
      .i_clr   (w_flush_go),
      .i_push  (w_push && !w_ovf),
      .i_din   (mul_result_tdata),
      .i_pop   (w_res_hs),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // State register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= DRAIN;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         DRAIN:   if (r_cnt == '0) w_state_nxt = RUN;
         RUN:     if (flush) w_state_nxt = FLUSH;
         FLUSH:   if (r_inflight == '0) w_state_nxt = RUN;
         default: w_state_nxt = DRAIN;
      endcase
   end

   // Drain timer covers any stale results still inside the core
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         r_cnt <= CNT_W'(MUL_LATENCY + 1);
      else if (r_state == DRAIN && r_cnt != '0)
         r_cnt <= r_cnt - CNT_W'(1);
   end

   // Reserved result slots: credit taken on issue, returned on delivery
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         r_reserved <= '0;
      else if (r_state == FLUSH && r_inflight == '0)
         r_reserved <= '0;
      else if (w_op_hs && !w_res_hs)
         r_reserved <= r_reserved + CW'(1);
      else if (!w_op_hs && w_res_hs)
         r_reserved <= r_reserved - CW'(1);
   end

   // Operations currently inside the core
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         r_inflight <= '0;
      else if (w_op_hs && !w_ret)
         r_inflight <= r_inflight + CW'(1);
      else if (!w_op_hs && w_ret)
         r_inflight <= r_inflight - CW'(1);
   end

   // Operand register feeding the core, one-cycle valid pulse per issue
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_mul_a <= '0;
         r_mul_b <= '0;
         r_mul_v <= 1'b0;
      end else begin
         r_mul_v <= w_op_hs;
         if (w_op_hs) begin
            r_mul_a <= s_op_a_tdata;
            r_mul_b <= s_op_b_tdata;
         end
      end
   end

   // Sticky error on orphan result or overflowing push
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_err <= 1'b0;
      else if (w_orphan || w_ovf) r_err <= 1'b1;
   end

`ifdef FP16_ISSUE_STATS_EN
   logic [STAT_W-1:0] r_stat_iss;
   logic [STAT_W-1:0] r_stat_ret;

   assign stat_issued   = r_stat_iss;
   assign stat_returned = r_stat_ret;

   // Free-running traffic counters, untouched by flush
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_stat_iss <= '0;
         r_stat_ret <= '0;
      end else begin
         if (w_op_hs)  r_stat_iss <= r_stat_iss + STAT_W'(1);
         if (w_res_hs) r_stat_ret <= r_stat_ret + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fp16_mul_issue.sv
// Scoreboard bench for fp16_mul_issue with a latency-accurate core stand-in.
// Directed vectors; expected products are hand-computed constants.
module tb_fp16_mul_issue;

   localparam int L = 6;
   localparam int D = 8;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [15:0] s_op_a_tdata;
   logic [15:0] s_op_b_tdata;
   logic        s_op_tvalid;
   logic        s_op_tready;
   logic [15:0] mul_a_tdata;
   logic [15:0] mul_b_tdata;
   logic        mul_a_tvalid;
   logic        mul_b_tvalid;
   logic        mul_result_tvalid;
   logic [15:0] mul_result_tdata;
   logic [15:0] m_res_tdata;
   logic        m_res_tvalid;
   logic        m_res_tready;
   logic        flush;
   logic        busy;
   logic        err;
`ifdef FP16_ISSUE_STATS_EN
   logic [31:0] stat_issued;
   logic [31:0] stat_returned;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_acc   = 0;
   logic [15:0] exp_q[$];

   logic [L-1:0] pv = '0;
   logic [15:0]  pd [L];
   logic         inj_v = 1'b0;
   logic [15:0]  inj_d = '0;

   always #5 aclk = ~aclk;

   fp16_mul_issue #(.FIFO_DEPTH(D), .MUL_LATENCY(L)) dut (
      .aclk              (aclk),
      .aresetn           (aresetn),
      .s_op_a_tdata      (s_op_a_tdata),
      .s_op_b_tdata      (s_op_b_tdata),
      .s_op_tvalid       (s_op_tvalid),
      .s_op_tready       (s_op_tready),
      .mul_a_tdata       (mul_a_tdata),
      .mul_b_tdata       (mul_b_tdata),
      .mul_a_tvalid      (mul_a_tvalid),
      .mul_b_tvalid      (mul_b_tvalid),
      .mul_result_tvalid (mul_result_tvalid),
      .mul_result_tdata  (mul_result_tdata),
      .m_res_tdata       (m_res_tdata),
      .m_res_tvalid      (m_res_tvalid),
      .m_res_tready      (m_res_tready),
      .flush             (flush),
      .busy              (busy),
      .err               (err)
`ifdef FP16_ISSUE_STATS_EN
      ,
      .stat_issued       (stat_issued),
      .stat_returned     (stat_returned)
`endif
   );

   function automatic logic [15:0] core_mul(input logic [15:0] a,
                                            input logic [15:0] b);
      if (a == 16'h3C00) return b;
      if (b == 16'h3C00) return a;
      if (a == 16'hB600 && b == 16'h7451) return 16'hEE7A;
      return 16'hDEAD;
   endfunction

   // Core stand-in: fixed L-cycle pipeline, no reset, no backpressure
   always @(posedge aclk) begin
      pv <= {pv[L-2:0], mul_a_tvalid & mul_b_tvalid};
      pd[0] <= core_mul(mul_a_tdata, mul_b_tdata);
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
   end

   assign mul_result_tvalid = pv[L-1] | inj_v;
   assign mul_result_tdata  = inj_v ? inj_d : pd[L-1];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: sample late in the low phase, after inputs settle
   always @(negedge aclk) begin
      #2;
      if (aresetn === 1'b1 && m_res_tvalid && m_res_tready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: got %0h expected none",
                     m_res_tdata);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (m_res_tdata !== e) begin
               n_fail++;
               $display("FAIL result_data: got %0h expected %0h",
                        m_res_tdata, e);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the handshake
   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] e);
      bit ok;
      ok = 0;
      s_op_a_tdata = a;
      s_op_b_tdata = b;
      s_op_tvalid  = 1'b1;
      for (int n = 0; n < 1000 && !ok; n++) begin
         if (s_op_tready) begin
            ok = 1;
            exp_q.push_back(e);
            n_acc++;
         end
         @(negedge aclk);
      end
      s_op_tvalid = 1'b0;
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: got no ready expected ready");
      end
   endtask

   task automatic wait_drain(input string nm);
      for (int n = 0; n < 300 && exp_q.size() != 0; n++)
         @(negedge aclk);
      repeat (2) @(negedge aclk);
      chk(nm, exp_q.size(), 0);
   endtask

   task automatic latency(input string nm);
      int k;
      k = 1;
      while (!m_res_tvalid && k < 40) begin
         @(negedge aclk);
         k++;
      end
      chk(nm, k, L + 2);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      aresetn      = 1'b0;
      s_op_a_tdata = '0;
      s_op_b_tdata = '0;
      s_op_tvalid  = 1'b0;
      m_res_tready = 1'b1;
      flush        = 1'b0;
      repeat (3) @(negedge aclk);

      chk("rst_tready", s_op_tready, 0);
      chk("rst_mulv", {mul_a_tvalid, mul_b_tvalid}, 0);
      chk("rst_muld", {mul_a_tdata, mul_b_tdata}, 0);
      chk("rst_resv", m_res_tvalid, 0);
      chk("rst_resd", m_res_tdata, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 1);

      // Offer an operand through reset release; must wait out the drain
      s_op_a_tdata = 16'hB600;
      s_op_b_tdata = 16'h7451;
      s_op_tvalid  = 1'b1;
      aresetn      = 1'b1;
      bad = 0;
      for (int k = 1; k < L + 2; k++) begin
         @(negedge aclk);
         if (s_op_tready || !busy) bad++;
      end
      chk("drain_hold", bad, 0);
      @(negedge aclk);
      chk("first_ready", s_op_tready, 1);

      send(16'hB600, 16'h7451, 16'hEE7A);
      latency("latency_ee7a");
      wait_drain("drain_ee7a");

      send(16'h3C00, 16'h4000, 16'h4000);
      latency("latency_4000");
      wait_drain("drain_4000");
      chk("idle_busy", busy, 0);

      // Backpressure: only FIFO_DEPTH credits available
      m_res_tready = 1'b0;
      n_acc = 0;
      fork
         for (int i = 0; i < 12; i++)
            send(16'h3C00, 16'h4100 + 16'(i), 16'h4100 + 16'(i));
      join_none
      repeat (40) @(negedge aclk);
      chk("bp_accepted", n_acc, D);
      chk("bp_tready", s_op_tready, 0);
      chk("bp_busy", busy, 1);
      m_res_tready = 1'b1;
      wait fork;
      wait_drain("bp_drain");
      chk("bp_total", n_acc, 12);

      // Flush with 3 results queued and 2 still in the core
      m_res_tready = 1'b0;
      for (int i = 0; i < 5; i++)
         send(16'h3C00, 16'h5000 + 16'(i), 16'h5000 + 16'(i));
      repeat (5) @(negedge aclk);
      chk("pre_flush_valid", m_res_tvalid, 1);
      exp_q.delete();
      flush = 1'b1;
      @(negedge aclk);
      flush = 1'b0;
      chk("flush_valid", m_res_tvalid, 0);
      chk("flush_tready", s_op_tready, 0);
      chk("flush_busy", busy, 1);
      m_res_tready = 1'b1;
      bad = 0;
      for (int n = 0; n < 30 && !s_op_tready; n++) begin
         @(negedge aclk);
         if (m_res_tvalid) bad++;
      end
      chk("flush_no_valid", bad, 0);
      chk("flush_rerun", s_op_tready, 1);
      chk("flush_idle", busy, 0);
      send(16'h3C00, 16'h4000, 16'h4000);
      latency("latency_post_flush");
      wait_drain("drain_post_flush");
      chk("flush_err", err, 0);

      // Orphan result in RUN
      inj_d = 16'h1234;
      inj_v = 1'b1;
      @(negedge aclk);
      inj_v = 1'b0;
      chk("orphan_err", err, 1);
      chk("orphan_nopush", m_res_tvalid, 0);
      repeat (3) @(negedge aclk);
      chk("orphan_sticky", err, 1);
      chk("orphan_valid", m_res_tvalid, 0);

      // Orphan result during DRAIN is ignored
      aresetn = 1'b0;
      @(negedge aclk);
      chk("rst2_err", err, 0);
      aresetn = 1'b1;
      repeat (2) @(negedge aclk);
      inj_v = 1'b1;
      @(negedge aclk);
      inj_v = 1'b0;
      chk("drain_inj_err", err, 0);
      for (int n = 0; n < 20 && !s_op_tready; n++) @(negedge aclk);
      chk("drain_inj_run", s_op_tready, 1);
      chk("drain_inj_err2", err, 0);
      chk("drain_inj_valid", m_res_tvalid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
